// File: rtl/axis_source.sv
// AXI-Stream burst source: COUNT beats of START_VALUE + k*STEP, TLAST on the final beat, optional idle gaps, stall counter.
// Optional macro AXIS_SRC_RAND_GAP_EN: pseudo-random gap length from an 8-bit LFSR instead of a fixed GAP_CYCLES.
module axis_source #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT       = 32,
  parameter int START_VALUE = 1,
  parameter int STEP        = 1,
  parameter int GAP_CYCLES  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  M_AXIS_TVALID,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           stall_cycles
);

  localparam int CW = $clog2(COUNT + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CW-1:0]         LAST_IDX = CW'(COUNT - 1);
  localparam logic [DATA_WIDTH-1:0] START_D  = DATA_WIDTH'(START_VALUE);
  localparam logic [DATA_WIDTH-1:0] STEP_D   = DATA_WIDTH'(STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         beat_cnt;
  logic [GW-1:0]         gap_cnt;
  logic [GW-1:0]         gap_len;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
  logic                  done_q;
  logic [15:0]           stall_q;

`ifdef AXIS_SRC_RAND_GAP_EN
  logic [7:0] lfsr;
  logic [7:0] lfsr_nxt;

  // x^8+x^6+x^5+x^4+1; gap length uses the value the LFSR steps to on this handshake
  assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign gap_len  = GW'(32'(lfsr_nxt) % (GAP_CYCLES + 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 8'h00;
    end else if (state == IDLE && start) begin
      lfsr <= 8'hA5;
    end else if (state == SEND && M_AXIS_TREADY) begin
      lfsr <= lfsr_nxt;
    end
  end
`else
  assign gap_len = GW'(GAP_CYCLES);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = SEND;
      SEND: begin
        if (M_AXIS_TREADY) begin
          if (tlast)                state_nxt = IDLE;
          else if (gap_len != '0)   state_nxt = GAP;
        end
      end
      GAP:  if (gap_cnt <= GW'(1)) state_nxt = SEND;
      default: state_nxt = IDLE;
    endcase
  end

  // Every output comes straight from a flop; TVALID never sees TREADY combinationally
  always_comb begin
    M_AXIS_TVALID = (state == SEND);
    busy          = (state != IDLE);
    M_AXIS_TDATA  = tdata;
    M_AXIS_TLAST  = tlast;
    done          = done_q;
    stall_cycles  = stall_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      gap_cnt  <= '0;
      tdata    <= '0;
      tlast    <= 1'b0;
      done_q   <= 1'b0;
      stall_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            beat_cnt <= '0;
            tdata    <= START_D;
            tlast    <= (COUNT == 1);
            stall_q  <= '0;
          end
        end
        SEND: begin
          if (M_AXIS_TREADY) begin
            if (tlast) begin
              tlast  <= 1'b0;
              done_q <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
              tdata    <= tdata + STEP_D;
              tlast    <= ((beat_cnt + CW'(1)) == LAST_IDX);
              gap_cnt  <= gap_len;
            end
          end else if (stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
          end
        end
        GAP: gap_cnt <= gap_cnt - GW'(1);
        default: ;
      endcase
    end
  end

endmodule
